// File: rtl/rs_encoder_stream.sv
// Streaming systematic RS(N,K) encoder over GF(2^SYMBOL_WIDTH) with two parity symbols.
// Data symbols pass straight through a one-entry output register while an LFSR built on
// g(x) = x^2 + G1*x + G0 accumulates the remainder. The two remainder symbols follow the
// data as parity. The full codeword is also presented in parallel, in the decoder's layout.
module rs_encoder_stream #(
  parameter int unsigned             N            = 18,
  parameter int unsigned             K            = 16,
  parameter int unsigned             SYMBOL_WIDTH = 5,
  parameter logic [SYMBOL_WIDTH-1:0] PRIM_POLY    = 5'b00101,
  parameter logic [SYMBOL_WIDTH-1:0] G1           = 5'd6,
  parameter logic [SYMBOL_WIDTH-1:0] G0           = 5'd8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SYMBOL_WIDTH-1:0]        in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SYMBOL_WIDTH-1:0]        out_data,
  output logic                           out_last,
  output logic [N*SYMBOL_WIDTH-1:0]      codeword,
  output logic                           cw_valid
);

  localparam int unsigned CntW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  typedef logic [SYMBOL_WIDTH-1:0] sym_t;

  typedef enum logic [1:0] {
    StData = 2'd0,
    StPar1 = 2'd1,
    StPar0 = 2'd2
  } state_e;

  // GF(2^m) multiply: shift-and-add with reduction by the primitive polynomial.
  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t acc;
    sym_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < int'(SYMBOL_WIDTH); i++) begin
      if (b[i]) begin
        acc = acc ^ sh;
      end
      sh = {sh[SYMBOL_WIDTH-2:0], 1'b0} ^ (sh[SYMBOL_WIDTH-1] ? PRIM_POLY : '0);
    end
    return acc;
  endfunction

  state_e                   state_q, state_d;
  logic [CntW-1:0]          sym_cnt_q, sym_cnt_d;
  sym_t                     r1_q, r1_d;
  sym_t                     r0_q, r0_d;
  logic                     out_valid_q, out_valid_d;
  sym_t                     out_data_q, out_data_d;
  logic                     out_last_q, out_last_d;
  logic [N-1:0][SYMBOL_WIDTH-1:0] cw_q, cw_d;
  logic                     cw_valid_q, cw_valid_d;

  logic                     out_free;
  logic                     in_fire;
  sym_t                     fb;
  logic [IdxW-1:0]          cw_idx;

  // The output entry can take a new symbol when empty or being drained this cycle.
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == StData) && out_free;
  assign in_fire  = in_valid && in_ready;

  // Feedback term and codeword slot for the incoming data symbol.
  always_comb begin
    fb     = in_data ^ r1_q;
    cw_idx = IdxW'(N - 1) - IdxW'(sym_cnt_q);
  end

  // Next-state for the FSM, LFSR, output entry and parallel codeword.
  always_comb begin
    state_d     = state_q;
    sym_cnt_d   = sym_cnt_q;
    r1_d        = r1_q;
    r0_d        = r0_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    cw_d        = cw_q;
    cw_valid_d  = 1'b0;

    unique case (state_q)
      StData: begin
        if (in_fire) begin
          r1_d           = r0_q ^ gf_mul(fb, G1);
          r0_d           = gf_mul(fb, G0);
          cw_d[cw_idx]   = in_data;
          out_valid_d    = 1'b1;
          out_data_d     = in_data;
          out_last_d     = 1'b0;
          if (sym_cnt_q == CntW'(K - 1)) begin
            sym_cnt_d = '0;
            state_d   = StPar1;
          end else begin
            sym_cnt_d = sym_cnt_q + CntW'(1);
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
      StPar1: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = r1_q;
          out_last_d  = 1'b0;
          cw_d[1]     = r1_q;
          state_d     = StPar0;
        end
      end
      StPar0: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = r0_q;
          out_last_d  = 1'b1;
          cw_d[0]     = r0_q;
          cw_valid_d  = 1'b1;
          // Clear the LFSR so the next frame starts from a zero remainder.
          r1_d        = '0;
          r0_d        = '0;
          state_d     = StData;
        end
      end
      default: begin
        state_d = StData;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StData;
      sym_cnt_q   <= '0;
      r1_q        <= '0;
      r0_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      cw_q        <= '0;
      cw_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_cnt_q   <= sym_cnt_d;
      r1_q        <= r1_d;
      r0_q        <= r0_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      cw_q        <= cw_d;
      cw_valid_q  <= cw_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign codeword  = cw_q;
  assign cw_valid  = cw_valid_q;

endmodule

// File: tb/tb_rs_encoder_stream.sv
// Self-checking bench for rs_encoder_stream: directed frames with hand-computed parity,
// backpressure, mid-frame reset, back-to-back frames, and syndrome checks on random data.
module tb_rs_encoder_stream;

  localparam int N = 18;
  localparam int K = 16;
  localparam int W = 5;

  typedef logic [W-1:0] sym_t;
  typedef sym_t frame_t [32];

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  sym_t             in_data;
  logic             out_valid;
  logic             out_ready;
  sym_t             out_data;
  logic             out_last;
  logic [N*W-1:0]   codeword;
  logic             cw_valid;

  rs_encoder_stream dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .codeword  (codeword),
    .cw_valid  (cw_valid)
  );

  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  int total = 0;
  int bad   = 0;

  sym_t           rx_q[$];
  logic           last_q[$];
  logic [N*W-1:0] cw_q[$];
  int             last_cw_cyc = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Independent field arithmetic for syndrome evaluation.
  function automatic sym_t gmul(input sym_t a, input sym_t b);
    sym_t acc;
    sym_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < W; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[W-2:0], 1'b0} ^ (sh[W-1] ? 5'b00101 : 5'b00000);
    end
    return acc;
  endfunction

  function automatic sym_t synd(input logic [N*W-1:0] c, input sym_t a);
    sym_t s;
    s = '0;
    for (int i = N - 1; i >= 0; i--) s = gmul(s, a) ^ c[i*W +: W];
    return s;
  endfunction

  // Output monitor: records transfers, cw pulses, and checks hold-while-stalled.
  initial begin
    logic prev_stall;
    sym_t prev_data;
    logic prev_last;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check_eq("hold_valid", 128'(out_valid), 128'(1'b1));
        check_eq("hold_data", 128'(out_data), 128'(prev_data));
        check_eq("hold_last", 128'(out_last), 128'(prev_last));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (out_valid && out_ready) begin
        rx_q.push_back(out_data);
        last_q.push_back(out_last);
      end
      if (cw_valid) begin
        cw_q.push_back(codeword);
        last_cw_cyc = cycle_cnt;
      end
    end
  end

  task automatic send(input frame_t d, input int n, input bit bp,
                      output int stalls, output int first_acc);
    int idx;
    int cyc;
    idx       = 0;
    cyc       = 0;
    stalls    = 0;
    first_acc = -1;
    while (idx < n && cyc < 4000) begin
      @(negedge clk);
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = 1'b1;
      in_data   = d[idx];
      #1;
      if (in_ready) begin
        if (idx == 0) first_acc = cycle_cnt;
        idx++;
      end else begin
        stalls++;
      end
      cyc++;
    end
    check_eq("send_done", 128'(idx), 128'(n));
    @(negedge clk);
    out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
  endtask

  task automatic drain(input int n, input bit bp);
    int cyc;
    cyc = 0;
    while (rx_q.size() < n && cyc < 1000) begin
      @(negedge clk);
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc++;
    end
    check_eq("drain_count", 128'(rx_q.size()), 128'(n));
    out_ready = 1'b1;
  endtask

  // Pops one frame from the monitor queues and checks data, out_last, codeword and syndromes.
  task automatic take_frame(input frame_t d, input int base, output logic [N*W-1:0] s);
    logic [N*W-1:0] exp_data;
    logic [N-1:0]   lv;
    logic [N*W-1:0] cw;
    s        = '0;
    lv       = '0;
    exp_data = '0;
    if (rx_q.size() < N || cw_q.size() == 0) begin
      check_eq("frame_avail", 128'(rx_q.size()), 128'(N));
      return;
    end
    for (int i = 0; i < N; i++) begin
      s[(N-1-i)*W +: W] = rx_q.pop_front();
      lv[N-1-i]         = last_q.pop_front();
    end
    for (int i = 0; i < K; i++) exp_data[(N-1-i)*W +: W] = d[base+i];
    check_eq("data_passthru", 128'(s[N*W-1:2*W]), 128'(exp_data[N*W-1:2*W]));
    check_eq("last_position", 128'(lv), 128'(18'd1));
    cw = cw_q.pop_front();
    check_eq("cw_vs_stream", 128'(cw), 128'(s));
    check_eq("syndrome_s1", 128'(synd(cw, 5'd2)), 128'(0));
    check_eq("syndrome_s2", 128'(synd(cw, 5'd4)), 128'(0));
  endtask

  initial begin
    frame_t         fz, f1, f2, fr, bb;
    logic [N*W-1:0] s, s_nb;
    int             st, fa;

    for (int i = 0; i < 32; i++) begin
      fz[i] = '0;
      f1[i] = '0;
      f2[i] = '0;
      bb[i] = '0;
      fr[i] = '0;
    end
    f1[15] = 5'd1;
    f2[14] = 5'd1;
    bb[15] = 5'd1;
    bb[30] = 5'd1;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_out_data", 128'(out_data), 128'(0));
    check_eq("rst_out_last", 128'(out_last), 128'(0));
    check_eq("rst_codeword", 128'(codeword), 128'(0));
    check_eq("rst_cw_valid", 128'(cw_valid), 128'(0));
    reset_n = 1'b1;

    // All-zero frame: 18 zero symbols, one cw pulse, 18 cycles from first accept.
    send(fz, K, 1'b0, st, fa);
    drain(N, 1'b0);
    check_eq("zero_cw_pulses", 128'(cw_q.size()), 128'(1));
    check_eq("zero_latency", 128'(last_cw_cyc - fa), 128'(18));
    take_frame(fz, 0, s);
    check_eq("zero_stream", 128'(s), 128'(0));

    // 15 zeros then 1: parity equals g(x) coefficients 6, 8.
    send(f1, K, 1'b0, st, fa);
    drain(N, 1'b0);
    check_eq("unit_cw_pulses", 128'(cw_q.size()), 128'(1));
    take_frame(f1, 0, s);
    check_eq("unit_stream", 128'(s), 128'({5'd1, 5'd6, 5'd8}));

    // x^3 mod g(x) = 28x + 21.
    send(f2, K, 1'b0, st, fa);
    drain(N, 1'b0);
    take_frame(f2, 0, s);
    check_eq("x3_stream", 128'(s), 128'({5'd1, 5'd0, 5'd28, 5'd21}));

    // Same frame under random backpressure.
    send(f2, K, 1'b1, st, fa);
    drain(N, 1'b1);
    check_eq("x3_bp_cw_pulses", 128'(cw_q.size()), 128'(1));
    take_frame(f2, 0, s);
    check_eq("x3_bp_stream", 128'(s), 128'({5'd1, 5'd0, 5'd28, 5'd21}));

    // Random frames: syndromes zero, stream identical with and without backpressure.
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < K; i++) fr[i] = sym_t'($urandom_range(0, 31));
      send(fr, K, 1'b0, st, fa);
      drain(N, 1'b0);
      take_frame(fr, 0, s_nb);
      send(fr, K, 1'b1, st, fa);
      drain(N, 1'b1);
      take_frame(fr, 0, s);
      check_eq("rand_bp_equal", 128'(s), 128'(s_nb));
    end

    // Reset after 7 accepted symbols drops the partial frame.
    for (int i = 0; i < K; i++) fr[i] = sym_t'($urandom_range(1, 31));
    send(fr, 7, 1'b0, st, fa);
    #2;
    check_eq("prerst_valid", 128'(out_valid), 128'(1));
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_valid", 128'(out_valid), 128'(0));
    check_eq("midrst_last", 128'(out_last), 128'(0));
    check_eq("midrst_codeword", 128'(codeword), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    rx_q.delete();
    last_q.delete();
    cw_q.delete();
    send(f1, K, 1'b0, st, fa);
    drain(N, 1'b0);
    check_eq("postrst_cw_pulses", 128'(cw_q.size()), 128'(1));
    take_frame(f1, 0, s);
    check_eq("postrst_stream", 128'(s), 128'({5'd1, 5'd6, 5'd8}));

    // Back-to-back frames with in_valid held: two stall cycles, independent parity.
    send(bb, 2 * K, 1'b0, st, fa);
    check_eq("b2b_stalls", 128'(st), 128'(2));
    drain(2 * N, 1'b0);
    check_eq("b2b_cw_pulses", 128'(cw_q.size()), 128'(2));
    take_frame(bb, 0, s);
    check_eq("b2b_first", 128'(s), 128'({5'd1, 5'd6, 5'd8}));
    take_frame(bb, K, s);
    check_eq("b2b_second", 128'(s), 128'({5'd1, 5'd0, 5'd28, 5'd21}));

    repeat (3) @(negedge clk);
    check_eq("tail_no_extra", 128'(rx_q.size() + cw_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
